alu_access_arbiter: RTL and testbench

- Shares the single ALU, and the operand-select code on its A and B multiplexers, between two requesters: the main control unit (requester 0) and the matrix address generator (requester 1).
- Performs round-robin arbitration and drives registered operand-select and opcode lines for a fixed ALU latency.
- Captures the ALU result and returns it to the winning requester with a one-cycle done pulse.
- Sits between the control/address logic and the ALU operand muxes.

---
 rtl/alu_access_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_access_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_access_arbiter.sv
// alu_access_arbiter: round-robin sharing of one ALU and its A/B operand muxes
// between the main control unit (requester 0) and the matrix address
// generator (requester 1). The winner's selects/opcode are held for ALU_LAT
// cycles, then the ALU result is captured and returned with a done pulse.
// Optional build macro ALU_ARB_SELCHK_EN: reject out-of-range select codes
// (above 4'b1001) with a sel_err + done pulse instead of issuing them.
module alu_access_arbiter #(
    parameter int DATA_W  = 19,
    parameter int SEL_W   = 4,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [SEL_W-1:0]  a_sel0,
    input  logic [SEL_W-1:0]  a_sel1,
    input  logic [SEL_W-1:0]  b_sel0,
    input  logic [SEL_W-1:0]  b_sel1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] alu_result,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic [SEL_W-1:0]  alu_a_sel,
    output logic [SEL_W-1:0]  alu_b_sel,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              sel_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t             state;
    logic [3:0]         lat_cnt;
    logic               last;   // requester granted most recently
    logic               owner;  // requester of the operation in flight
    logic               win;
    logic               sel_bad;
    logic [SEL_W-1:0]   win_a;
    logic [SEL_W-1:0]   win_b;
    logic [OP_W-1:0]    win_op;

    // Winner selection: a lone request wins, a tie goes to the one not served last
    always_comb begin
        win    = (req0 && req1) ? ~last : req1;
        win_a  = win ? a_sel1 : a_sel0;
        win_b  = win ? b_sel1 : b_sel0;
        win_op = win ? op1 : op0;
    end

`ifdef ALU_ARB_SELCHK_EN
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(9);
    // Legal mux codes are 0..9; anything above is refused before issue
    always_comb sel_bad = (win_a > SEL_MAX) || (win_b > SEL_MAX);
`else
    // Without checking, an out-of-range code is simply issued (mux yields 0)
    always_comb sel_bad = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Arbitration FSM with registered grant, select, opcode and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            sel_err   <= 1'b0;
            result    <= '0;
            alu_a_sel <= '0;
            alu_b_sel <= '0;
            alu_op    <= '0;
        end else begin
            done0   <= 1'b0;
            done1   <= 1'b0;
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        last  <= win;
                        owner <= win;
                        if (sel_bad) begin
                            // Refused: report through done + sel_err, result untouched
                            done0   <= ~win;
                            done1   <= win;
                            sel_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            alu_a_sel <= win_a;
                            alu_b_sel <= win_b;
                            alu_op    <= win_op;
                            gnt0      <= ~win;
                            gnt1      <= win;
                            lat_cnt   <= 4'(ALU_LAT - 1);
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        result    <= alu_result;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        alu_a_sel <= '0;
                        alu_b_sel <= '0;
                        alu_op    <= '0;
                        done0     <= ~owner;
                        done1     <= owner;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_access_arbiter.sv
// Bench for alu_access_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) share
// one set of inputs. A transaction-level model records each grant (who, when,
// operands) and derives every expected output from the grant time and latency.
module tb_alu_access_arbiter;

    localparam int DW = 19;
    localparam int SW = 4;
    localparam int OW = 3;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
`ifdef ALU_ARB_SELCHK_EN
    localparam bit SELCHK = 1'b1;
`else
    localparam bit SELCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [SW-1:0] a_sel0 = '0, a_sel1 = '0, b_sel0 = '0, b_sel1 = '0;
    logic [OW-1:0] op0 = '0, op1 = '0;
    logic [DW-1:0] alu_result = '0;

    logic          gnt0_o [2], gnt1_o [2], done0_o [2], done1_o [2], busy_o [2], err_o [2];
    logic [DW-1:0] res_o [2];
    logic [SW-1:0] as_o [2], bs_o [2];
    logic [OW-1:0] op_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_access_arbiter #(.DATA_W(DW), .SEL_W(SW), .OP_W(OW), .ALU_LAT(LAT0)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a_sel0(a_sel0), .a_sel1(a_sel1), .b_sel0(b_sel0), .b_sel1(b_sel1),
        .op0(op0), .op1(op1), .alu_result(alu_result),
        .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .done0(done0_o[0]), .done1(done1_o[0]),
        .result(res_o[0]), .alu_a_sel(as_o[0]), .alu_b_sel(bs_o[0]), .alu_op(op_o[0]),
        .busy(busy_o[0]), .sel_err(err_o[0]));

    alu_access_arbiter #(.DATA_W(DW), .SEL_W(SW), .OP_W(OW), .ALU_LAT(LAT1)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a_sel0(a_sel0), .a_sel1(a_sel1), .b_sel0(b_sel0), .b_sel1(b_sel1),
        .op0(op0), .op1(op1), .alu_result(alu_result),
        .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .done0(done0_o[1]), .done1(done1_o[1]),
        .result(res_o[1]), .alu_a_sel(as_o[1]), .alu_b_sel(bs_o[1]), .alu_op(op_o[1]),
        .busy(busy_o[1]), .sel_err(err_o[1]));

    // ---------------- reference model: one record per instance ----------------
    int            cyc = 0;
    bit            m_act [2], m_err [2], m_win [2], m_last [2];
    int            m_tg [2];
    logic [SW-1:0] m_a [2], m_b [2];
    logic [OW-1:0] m_op [2];
    logic [DW-1:0] m_res [2];

    function automatic int lat(int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // A refused request completes in zero issue cycles
    function automatic int eff(int k);
        return m_err[k] ? 0 : lat(k);
    endfunction

    function automatic bit x_gnt(int k, bit who);
        return m_act[k] && !m_err[k] && (m_win[k] == who) && cyc >= m_tg[k] && cyc < m_tg[k] + lat(k);
    endfunction

    function automatic bit x_done(int k, bit who);
        return m_act[k] && (m_win[k] == who) && cyc == m_tg[k] + eff(k);
    endfunction

    function automatic bit x_busy(int k);
        return m_act[k] && cyc >= m_tg[k] && cyc <= m_tg[k] + eff(k);
    endfunction

    function automatic bit x_err(int k);
        return m_act[k] && m_err[k] && cyc == m_tg[k];
    endfunction

    function automatic bit m_idle(int k);
        return !m_act[k] || cyc >= m_tg[k] + eff(k) + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0; m_err[k] = 1'b0; m_last[k] = 1'b1; m_res[k] = '0;
        end
    endtask

    task automatic model_edge(int k);
        bit w;
        if (m_act[k] && !m_err[k] && cyc == m_tg[k] + lat(k)) m_res[k] = alu_result;
        if ((!m_act[k] || cyc >= m_tg[k] + eff(k) + 2) && (req0 || req1)) begin
            w = (req0 && req1) ? !m_last[k] : req1;
            m_last[k] = w; m_win[k] = w; m_act[k] = 1'b1; m_tg[k] = cyc;
            m_a[k] = w ? a_sel1 : a_sel0;
            m_b[k] = w ? b_sel1 : b_sel0;
            m_op[k] = w ? op1 : op0;
            m_err[k] = SELCHK && (m_a[k] > 4'd9 || m_b[k] > 4'd9);
        end
    endtask

    // One clock edge: advance the model and land 1ns after the edge
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            for (int k = 0; k < 2; k++) model_edge(k);
        end
        #1;
    endtask

    task automatic idle_wait();
        int n = 0;
        req0 = 1'b0; req1 = 1'b0;
        while (!(m_idle(0) && m_idle(1)) && n < 20) begin step(); n++; end
        if (n >= 20) begin
            n_bad++;
            $display("FAIL idle_wait got busy after %0d cycles want idle", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({gnt0_o[k], gnt1_o[k], done0_o[k], done1_o[k], busy_o[k], err_o[k], res_o[k],
                 as_o[k], bs_o[k], op_o[k]} !== '0) begin
                n_bad++;
                $display("FAIL reset_state k=%0d got gnt=%b%b done=%b%b busy=%b res=%h sel=%h/%h want all 0",
                         k, gnt0_o[k], gnt1_o[k], done0_o[k], done1_o[k], busy_o[k], res_o[k], as_o[k], bs_o[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        req0 = 1'b1; a_sel0 = 4'd3; b_sel0 = 4'd5; op0 = 3'd1;
        step();
        n_cmp++;
        if ({gnt0_o[0], as_o[0], bs_o[0], op_o[0]} !== {1'b1, 4'd3, 4'd5, 3'd1}) begin
            n_bad++;
            $display("FAIL single_issue got gnt0=%b a=%h b=%h op=%h want 1 3 5 1", gnt0_o[0], as_o[0], bs_o[0], op_o[0]);
        end
        alu_result = 19'h00ABC;
        step();
        n_cmp++;
        if ({done0_o[0], gnt0_o[0], res_o[0], as_o[0], bs_o[0], op_o[0]} !== {1'b1, 1'b0, 19'h00ABC, 4'd0, 4'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL single_done got done0=%b gnt0=%b res=%h a=%h b=%h want 1 0 00abc 0 0",
                     done0_o[0], gnt0_o[0], res_o[0], as_o[0], bs_o[0]);
        end
        req0 = 1'b0;
    endtask

    task automatic test_tie();
        bit q [2][$];
        bit prev [2];
        bit want [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0; #2; model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        prev[0] = 1'b0; prev[1] = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a_sel0 = 4'd1; a_sel1 = 4'd2; b_sel0 = 4'd3; b_sel1 = 4'd4;
        for (int c = 0; c < 40; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (!prev[k] && (gnt0_o[k] || gnt1_o[k])) q[k].push_back(gnt1_o[k]);
                prev[k] = gnt0_o[k] || gnt1_o[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (q[k].size() <= i) begin
                    n_bad++;
                    $display("FAIL tie_order k=%0d grant %0d got none want %0d", k, i, want[i]);
                end else if (q[k][i] !== want[i]) begin
                    n_bad++;
                    $display("FAIL tie_order k=%0d grant %0d got %0d want %0d", k, i, q[k][i], want[i]);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] v;
        v = '0;
        req1 = 1'b1; a_sel1 = 4'd7; b_sel1 = 4'd2; op1 = 3'd5;
        step();
        for (int i = 1; i <= 3; i++) begin
            n_cmp++;
            if ({gnt1_o[1], done1_o[1], as_o[1], bs_o[1], op_o[1]} !== {1'b1, 1'b0, 4'd7, 4'd2, 3'd5}) begin
                n_bad++;
                $display("FAIL latency_hold cycle %0d got gnt1=%b done1=%b a=%h b=%h op=%h want 1 0 7 2 5",
                         i, gnt1_o[1], done1_o[1], as_o[1], bs_o[1], op_o[1]);
            end
            a_sel1 = 4'($urandom); b_sel1 = 4'($urandom); op1 = 3'($urandom);
            alu_result = DW'($urandom);
            v = alu_result;
            step();
        end
        n_cmp++;
        if ({done1_o[1], gnt1_o[1], res_o[1]} !== {1'b1, 1'b0, v}) begin
            n_bad++;
            $display("FAIL latency_done got done1=%b gnt1=%b res=%h want 1 0 %h", done1_o[1], gnt1_o[1], res_o[1], v);
        end
        req1 = 1'b0;
    endtask

    task automatic test_drop();
        logic [DW-1:0] cap [5];
        req0 = 1'b1; a_sel0 = 4'd9; b_sel0 = 4'd8; op0 = 3'd6;
        step();
        req0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            alu_result = DW'($urandom);
            cap[i] = alu_result;
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (done0_o[k] !== (i == lat(k))) begin
                    n_bad++;
                    $display("FAIL drop_done k=%0d i=%0d got %b want %b", k, i, done0_o[k], i == lat(k));
                end
                if (i == lat(k)) begin
                    n_cmp++;
                    if (res_o[k] !== cap[i]) begin
                        n_bad++;
                        $display("FAIL drop_result k=%0d got %h want %h", k, res_o[k], cap[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        req1 = 1'b1; a_sel1 = 4'd4; b_sel1 = 4'd6; op1 = 3'd2;
        step();
        req1 = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({gnt0_o[k], gnt1_o[k], done0_o[k], done1_o[k], busy_o[k], err_o[k], res_o[k],
                 as_o[k], bs_o[k], op_o[k]} !== '0) begin
                n_bad++;
                $display("FAIL abort_clear k=%0d got gnt1=%b busy=%b a=%h res=%h want all 0",
                         k, gnt1_o[k], busy_o[k], as_o[k], res_o[k]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done1_o[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done got %b want 0", done1_o[1]);
        end
        rst_n = 1'b1;
        req1 = 1'b1;
        step();
        n_cmp++;
        if ({gnt1_o[1], gnt0_o[1], as_o[1]} !== {1'b1, 1'b0, 4'd4}) begin
            n_bad++;
            $display("FAIL abort_regrant got gnt1=%b gnt0=%b a=%h want 1 0 4", gnt1_o[1], gnt0_o[1], as_o[1]);
        end
        req1 = 1'b0;
    endtask

    task automatic test_selchk();
        req0 = 1'b1; a_sel0 = 4'b1010; b_sel0 = 4'd1; op0 = 3'd2;
        step();
        req0 = 1'b0;
`ifdef ALU_ARB_SELCHK_EN
        n_cmp++;
        if ({gnt0_o[0], err_o[0], done0_o[0], as_o[0], res_o[0]} !== {1'b0, 1'b1, 1'b1, 4'd0, m_res[0]}) begin
            n_bad++;
            $display("FAIL selchk_reject got gnt0=%b err=%b done0=%b a=%h res=%h want 0 1 1 0 %h",
                     gnt0_o[0], err_o[0], done0_o[0], as_o[0], res_o[0], m_res[0]);
        end
`else
        n_cmp++;
        if ({gnt0_o[0], err_o[0], as_o[0]} !== {1'b1, 1'b0, 4'b1010}) begin
            n_bad++;
            $display("FAIL selchk_pass got gnt0=%b err=%b a=%h want 1 0 a", gnt0_o[0], err_o[0], as_o[0]);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0]           fl_act, fl_exp;
        logic [SW+SW+OW-1:0]  s_act, s_exp;
        for (int c = 0; c < 1500; c++) begin
            req0 = ($urandom_range(0, 9) < 6);
            req1 = ($urandom_range(0, 9) < 6);
            a_sel0 = 4'($urandom); a_sel1 = 4'($urandom);
            b_sel0 = 4'($urandom_range(0, 11)); b_sel1 = 4'($urandom_range(0, 11));
            op0 = 3'($urandom); op1 = 3'($urandom);
            alu_result = DW'($urandom);
            step();
            for (int k = 0; k < 2; k++) begin
                fl_act = {gnt0_o[k], gnt1_o[k], done0_o[k], done1_o[k], busy_o[k], err_o[k]};
                fl_exp = {x_gnt(k, 0), x_gnt(k, 1), x_done(k, 0), x_done(k, 1), x_busy(k), x_err(k)};
                n_cmp++;
                if (fl_act !== fl_exp) begin
                    n_bad++;
                    $display("FAIL rand_flags k=%0d cyc=%0d got %b want %b", k, cyc, fl_act, fl_exp);
                end
                s_act = {as_o[k], bs_o[k], op_o[k]};
                s_exp = x_gnt(k, m_win[k]) ? {m_a[k], m_b[k], m_op[k]} : '0;
                n_cmp++;
                if (s_act !== s_exp) begin
                    n_bad++;
                    $display("FAIL rand_sel k=%0d cyc=%0d got %h want %h", k, cyc, s_act, s_exp);
                end
                n_cmp++;
                if (res_o[k] !== m_res[k]) begin
                    n_bad++;
                    $display("FAIL rand_result k=%0d cyc=%0d got %h want %h", k, cyc, res_o[k], m_res[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        idle_wait();
        test_tie();
        idle_wait();
        test_latency();
        idle_wait();
        test_drop();
        idle_wait();
        test_abort();
        idle_wait();
        test_selchk();
        idle_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
